// File: rtl/ibuf.sv
// Input pin conditioner: raw combinational pass-through plus synchronized,
// glitch-filtered and edge-pulse views of an asynchronous pin in the osc domain.
module ibuf #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic osc,
  input  logic rst_n,
  input  logic I,
  output logic O,
  output logic O_sync,
  output logic O_filt,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_nxt_s;
  logic                   filt_r;
  logic                   filt_nxt_s;
  logic                   rise_r;
  logic                   rise_nxt_s;
  logic                   fall_r;
  logic                   fall_nxt_s;

  assign O      = I;
  assign sync_s = sync_r[SYNC_STAGES-1];
  assign O_sync = sync_s;
  assign O_filt = filt_r;
  assign rise   = rise_r;
  assign fall   = fall_r;

  // Synchronizer shift chain; bit 0 captures the raw pin.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], I};
    end
  end

  // Filter decision: the counter clears at the threshold, so it can never wrap.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    filt_nxt_s = filt_r;
    rise_nxt_s = 1'b0;
    fall_nxt_s = 1'b0;
    if (sync_s == filt_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s  = CNT_ZERO;
      filt_nxt_s = sync_s;
      rise_nxt_s = sync_s;
      fall_nxt_s = ~sync_s;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Filter state and edge pulses, registered together so a pulse coincides
  // with the first cycle that shows the new filtered level.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= CNT_ZERO;
      filt_r <= RESET_LEVEL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      filt_r <= filt_nxt_s;
      rise_r <= rise_nxt_s;
      fall_r <= fall_nxt_s;
    end
  end

endmodule

// File: tb/tb_ibuf.sv
// Bench for ibuf: two configurations (2 stages/filter 3, 3 stages/filter 0)
// compared every cycle against a history-window model, plus literal scenarios.
module tb_ibuf;

  logic       osc = 1'b0;
  logic       rst_n;
  logic       I;
  logic [1:0] o, o_sync, o_filt, rise, fall;
  logic [1:0] e_sync, e_filt, e_rise, e_fall;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 osc = ~osc;

  // True when the window holds exactly n samples and none equals v.
  function automatic bit all_differ(input bit q[$], input int n, input bit v);
    if (q.size() != n) return 1'b0;
    foreach (q[k]) if (q[k] == v) return 1'b0;
    return 1'b1;
  endfunction

  for (genvar m = 0; m < 2; m++) begin : g_inst
    localparam int S = (m == 0) ? 2 : 3;
    localparam int F = (m == 0) ? 3 : 0;

    ibuf #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .RESET_LEVEL(1'b0)) dut (
      .osc(osc), .rst_n(rst_n), .I(I), .O(o[m]), .O_sync(o_sync[m]),
      .O_filt(o_filt[m]), .rise(rise[m]), .fall(fall[m])
    );

    // Model: O_sync is the pin sampled S edges ago; O_filt flips once the
    // last F+1 pre-edge O_sync samples all disagree with it.
    bit i_hist[$];
    bit s_hist[$];
    bit ms = 1'b0, mf = 1'b0, mr = 1'b0, mfl = 1'b0;

    always @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
        i_hist.delete();
        s_hist.delete();
        ms  <= 1'b0;
        mf  <= 1'b0;
        mr  <= 1'b0;
        mfl <= 1'b0;
      end else begin
        s_hist.push_back(ms);
        if (s_hist.size() > F + 1) s_hist.pop_front();
        i_hist.push_back(I);
        if (i_hist.size() > S) i_hist.pop_front();
        ms <= (i_hist.size() == S) ? i_hist[0] : 1'b0;
        if (all_differ(s_hist, F + 1, mf)) begin
          mf  <= ~mf;
          mr  <= ~mf;
          mfl <= mf;
        end else begin
          mr  <= 1'b0;
          mfl <= 1'b0;
        end
      end
    end

    assign e_sync[m] = ms;
    assign e_filt[m] = mf;
    assign e_rise[m] = mr;
    assign e_fall[m] = mfl;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge osc);
      chk("O", {30'd0, o}, {30'd0, I, I});
      chk("O_sync", {30'd0, o_sync}, {30'd0, e_sync});
      chk("O_filt", {30'd0, o_filt}, {30'd0, e_filt});
      chk("rise", {30'd0, rise}, {30'd0, e_rise});
      chk("fall", {30'd0, fall}, {30'd0, e_fall});
      chk("rise_and_fall", {30'd0, rise & fall}, 32'd0);
    end
  end

  initial begin
    int hi;
    int bad;
    rst_n = 1'b0;
    I     = 1'b1;
    repeat (2) @(posedge osc);
    #2;
    chk("rst O", {31'd0, o[0]}, 32'd1);
    chk("rst O_sync", {30'd0, o_sync}, 32'd0);
    chk("rst O_filt", {30'd0, o_filt}, 32'd0);
    chk("rst pulses", {28'd0, rise, fall}, 32'd0);

    // Rising step held through release.
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge osc);
      #1;
      if (e == 1) chk("step sync e1", {31'd0, o_sync[0]}, 32'd0);
      if (e == 2) chk("step sync e2", {31'd0, o_sync[0]}, 32'd1);
      if (e == 5) chk("step filt e5", {31'd0, o_filt[0]}, 32'd0);
      if (e == 6) chk("step filt e6", {31'd0, o_filt[0]}, 32'd1);
      if (e == 6) chk("step rise e6", {31'd0, rise[0]}, 32'd1);
      if (e == 7) chk("step rise e7", {31'd0, rise[0]}, 32'd0);
      if (e == 3) chk("f0 filt e3", {31'd0, o_filt[1]}, 32'd0);
      if (e == 4) chk("f0 filt e4", {31'd0, o_filt[1]}, 32'd1);
      if (e == 4) chk("f0 rise e4", {31'd0, rise[1]}, 32'd1);
      if (e == 5) chk("f0 rise e5", {31'd0, rise[1]}, 32'd0);
    end

    // Falling step from settled 1.
    #1 I = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge osc);
      #1;
      if (e == 5) chk("fall e5", {31'd0, fall[0]}, 32'd0);
      if (e == 5) chk("fall filt e5", {31'd0, o_filt[0]}, 32'd1);
      if (e == 6) chk("fall e6", {31'd0, fall[0]}, 32'd1);
      if (e == 6) chk("fall filt e6", {31'd0, o_filt[0]}, 32'd0);
      if (e == 7) chk("fall e7", {31'd0, fall[0]}, 32'd0);
      if (e == 8) chk("fall filt e8", {31'd0, o_filt[0]}, 32'd0);
    end
    repeat (6) @(posedge osc);
    #2;

    // Three-cycle glitch must be rejected by the default filter.
    I   = 1'b1;
    hi  = 0;
    bad = 0;
    for (int e = 1; e <= 14; e++) begin
      @(posedge osc);
      #1;
      hi += int'(o_sync[0]);
      if (o_filt[0] !== 1'b0 || rise[0] !== 1'b0) bad++;
      if (e == 3) #1 I = 1'b0;
    end
    chk("glitch sync width", hi, 32'd3);
    chk("glitch rejected", bad, 32'd0);
    #1;

    // Reset while the counter is part-way to the threshold.
    I = 1'b1;
    repeat (4) @(posedge osc);
    #1;
    chk("mid sync", {31'd0, o_sync[0]}, 32'd1);
    chk("mid filt", {31'd0, o_filt[0]}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst filt", {31'd0, o_filt[0]}, 32'd0);
    chk("mid rst sync", {31'd0, o_sync[0]}, 32'd0);
    repeat (2) @(posedge osc);
    chk("mid rst rise", {31'd0, rise[0]}, 32'd0);
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge osc);
      #1;
      if (e == 5) chk("rel filt e5", {31'd0, o_filt[0]}, 32'd0);
      if (e == 6) chk("rel filt e6", {31'd0, o_filt[0]}, 32'd1);
      if (e == 6) chk("rel rise e6", {31'd0, rise[0]}, 32'd1);
    end
    #1;

    // Random pin activity with hold times straddling both filter thresholds.
    for (int n = 0; n < 400; n++) begin
      I = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) @(posedge osc);
      #2;
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        @(posedge osc);
        #2 rst_n = 1'b1;
      end
    end

    repeat (3) @(posedge osc);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
